// File: rtl/simple_dpi_param_sequencer.sv
// -----------------------------------------------------------------------------
// simple_dpi_param_sequencer
//
// Sequences the simple_dpi generated component. Samples are accepted over a
// valid/ready handshake and forwarded to the DUT inputs. Each result is tagged
// with out_valid once the DUT latency has elapsed. Runtime parameter updates
// (opt1_f, valid) are applied only after every in-flight sample has produced
// its result. A settle window with clk_enable low follows each update.
//
// Handshake semantics: a transfer happens on a rising clk edge where both
// in_valid and in_ready are high. in_ready is combinational (RUN and no
// cfg_req), so it may drop in the same cycle that cfg_req rises. The
// requester holds cfg_req and the cfg_* values until cfg_ack pulses.
//
// Parameters:
//   DATA_W        sample and parameter width
//   LATENCY       DUT cycles from enabled input to valid outputArg11 (1..8)
//   SETTLE_CYCLES clk_enable-low cycles after a parameter load (1..15)
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_arg1, in_arg2       sample input
//   cfg_req, cfg_opt1_f, cfg_valid, cfg_ack   parameter update request
//   dut_clk_enable, dut_inputArg1/2           to DUT
//   dut_outputArg11                           from DUT
//   dut_opt1_f, dut_param_valid, dut_param_load  parameter bus to wrapper
//   out_valid, out_data                       result strobe and data
//   busy                                      not RUN, or samples in flight
//   dbg_state                                 current FSM state
//
// Optional feature macro: SIMPLE_SEQ_STATS_EN adds sample_count (16b) and
// cfg_count (8b) statistics outputs.
// -----------------------------------------------------------------------------
module simple_dpi_param_sequencer #(
  parameter int DATA_W        = 8,
  parameter int LATENCY       = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_arg1,
  input  logic [DATA_W-1:0] in_arg2,
  input  logic              cfg_req,
  input  logic [DATA_W-1:0] cfg_opt1_f,
  input  logic              cfg_valid,
  output logic              cfg_ack,
  output logic              dut_clk_enable,
  output logic [DATA_W-1:0] dut_inputArg1,
  output logic [DATA_W-1:0] dut_inputArg2,
  input  logic [DATA_W-1:0] dut_outputArg11,
  output logic [DATA_W-1:0] dut_opt1_f,
  output logic              dut_param_valid,
  output logic              dut_param_load,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [1:0]        dbg_state
`ifdef SIMPLE_SEQ_STATS_EN
  ,
  output logic [15:0]       sample_count,
  output logic [7:0]        cfg_count
`endif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_LOAD   = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  state_t            r_state;
  // Bit 0 marks a sample sitting in the DUT input register; bits 1..LATENCY
  // follow it through the DUT. The tail bit is high in the cycle the DUT
  // output for that sample is valid, so the result register captures it.
  logic [LATENCY:0]  r_vld_sr;
  logic [3:0]        r_settle_cnt;
  logic              r_clk_en;
  logic [DATA_W-1:0] r_arg1;
  logic [DATA_W-1:0] r_arg2;
  logic [DATA_W-1:0] r_opt1_f;
  logic              r_param_valid;
  logic              r_param_load;
  logic              r_cfg_ack;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;

  logic              w_accept;
  logic              w_pipe_empty;
  logic              w_tail;
  logic              w_load_go;
  logic [3:0]        w_settle_next;

  assign in_ready      = (r_state == S_RUN) && !cfg_req;
  assign w_accept      = in_valid && in_ready;
  assign w_pipe_empty  = (r_vld_sr == '0);
  assign w_tail        = r_vld_sr[LATENCY];
  assign w_load_go     = (r_state == S_DRAIN) && w_pipe_empty;
  assign w_settle_next = r_settle_cnt - 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_RUN;
      r_vld_sr      <= '0;
      r_settle_cnt  <= '0;
      r_clk_en      <= 1'b0;
      r_arg1        <= '0;
      r_arg2        <= '0;
      r_opt1_f      <= '0;
      r_param_valid <= 1'b0;
      r_param_load  <= 1'b0;
      r_cfg_ack     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
    end else begin
      r_vld_sr     <= {r_vld_sr[LATENCY-1:0], w_accept};
      r_out_valid  <= w_tail;
      if (w_tail) begin
        r_out_data <= dut_outputArg11;
      end
      r_param_load <= 1'b0;
      r_cfg_ack    <= 1'b0;

      case (r_state)
        S_RUN: begin
          // Also lifts clk_enable in the first cycle after reset release.
          r_clk_en <= 1'b1;
          if (w_accept) begin
            r_arg1 <= in_arg1;
            r_arg2 <= in_arg2;
          end
          if (cfg_req) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pipe_empty) begin
            r_state      <= S_LOAD;
            r_param_load <= 1'b1;
            r_cfg_ack    <= 1'b1;
            r_clk_en     <= 1'b0;
          end
        end
        S_LOAD: begin
          // Values present in the LOAD cycle are taken even if cfg_req
          // was dropped early.
          r_opt1_f      <= cfg_opt1_f;
          r_param_valid <= cfg_valid;
          r_settle_cnt  <= LP_SETTLE;
          r_state       <= S_SETTLE;
        end
        S_SETTLE: begin
          r_settle_cnt <= w_settle_next;
          if (w_settle_next == 4'd0) begin
            r_state  <= S_RUN;
            r_clk_en <= 1'b1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign cfg_ack         = r_cfg_ack;
  assign dut_clk_enable  = r_clk_en;
  assign dut_inputArg1   = r_arg1;
  assign dut_inputArg2   = r_arg2;
  assign dut_opt1_f      = r_opt1_f;
  assign dut_param_valid = r_param_valid;
  assign dut_param_load  = r_param_load;
  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign busy            = (r_state != S_RUN) || !w_pipe_empty;
  assign dbg_state       = r_state;

`ifdef SIMPLE_SEQ_STATS_EN
  logic [15:0] r_sample_cnt;
  logic [7:0]  r_cfg_cnt;

  // Counters wrap naturally; neither event can occur during SETTLE, the
  // gate keeps them frozen there regardless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample_cnt <= '0;
      r_cfg_cnt    <= '0;
    end else if (r_state != S_SETTLE) begin
      if (w_tail) begin
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end
      if (w_load_go) begin
        r_cfg_cnt <= r_cfg_cnt + 8'd1;
      end
    end
  end

  assign sample_count = r_sample_cnt;
  assign cfg_count    = r_cfg_cnt;
`endif

endmodule

// File: tb/tb_simple_dpi_param_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for simple_dpi_param_sequencer. A small behavioural stand-in for the
// simple_dpi component produces outputArg11 = arg1 + arg2 (+ opt1_f when the
// parameter is valid) after LATENCY enabled cycles.
// -----------------------------------------------------------------------------
module tb_simple_dpi_param_sequencer;

  localparam int W   = 8;
  localparam int LAT = 1;
  localparam int SET = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- signals
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_arg1 = '0;
  logic [W-1:0] in_arg2 = '0;
  logic         cfg_req = 1'b0;
  logic [W-1:0] cfg_opt1_f = '0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ack;
  logic         dut_clk_enable;
  logic [W-1:0] dut_inputArg1;
  logic [W-1:0] dut_inputArg2;
  logic [W-1:0] dut_outputArg11;
  logic [W-1:0] dut_opt1_f;
  logic         dut_param_valid;
  logic         dut_param_load;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         busy;
  logic [1:0]   dbg_state;
`ifdef SIMPLE_SEQ_STATS_EN
  logic [15:0]  sample_count;
  logic [7:0]   cfg_count;
`endif

  simple_dpi_param_sequencer #(
    .DATA_W(W), .LATENCY(LAT), .SETTLE_CYCLES(SET)
  ) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_arg1(in_arg1), .in_arg2(in_arg2),
    .cfg_req(cfg_req), .cfg_opt1_f(cfg_opt1_f), .cfg_valid(cfg_valid),
    .cfg_ack(cfg_ack),
    .dut_clk_enable(dut_clk_enable),
    .dut_inputArg1(dut_inputArg1), .dut_inputArg2(dut_inputArg2),
    .dut_outputArg11(dut_outputArg11),
    .dut_opt1_f(dut_opt1_f), .dut_param_valid(dut_param_valid),
    .dut_param_load(dut_param_load),
    .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .dbg_state(dbg_state)
`ifdef SIMPLE_SEQ_STATS_EN
    , .sample_count(sample_count), .cfg_count(cfg_count)
`endif
  );

  // ---------------------------------------------------------------- DUT stand-in
  function automatic logic [W-1:0] dpi_func(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] opt, input logic pv);
    return a + b + (pv ? opt : '0);
  endfunction

  logic [W-1:0] stub_pipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    if (dut_clk_enable) begin
      stub_pipe[0] <= dpi_func(dut_inputArg1, dut_inputArg2, dut_opt1_f, dut_param_valid);
      for (int i = 1; i < LAT; i++) stub_pipe[i] <= stub_pipe[i-1];
    end
  end
  assign dut_outputArg11 = stub_pipe[LAT-1];

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [W-1:0] exp_q[$];
  int           t_q[$];
  logic [W-1:0] obs_q[$];
  int           obs_t_q[$];
  logic [W-1:0] model_opt = '0;
  logic         model_pv = 1'b0;
  int           last_out_cyc = 0;
  int           n_out = 0;

  // Reference rules: a sample handshaked in the cycle sampled here produces
  // out_valid LAT+1 cycles after the handshake edge, using the parameters in
  // force when it was accepted. Parameters change on cfg_ack.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      t_q.delete();
      model_opt = '0;
      model_pv  = 1'b0;
    end else begin
      while (t_q.size() > 0 && t_q[0] < cyc) begin
        chk("out_valid_missing", 0, 1);
        void'(t_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (out_valid) begin
        obs_q.push_back(out_data);
        obs_t_q.push_back(cyc);
        n_out++;
        if (exp_q.size() == 0) begin
          chk("out_valid_unexpected", 1, 0);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
          chk("out_valid_cycle", cyc, t_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(dpi_func(in_arg1, in_arg2, model_opt, model_pv));
        t_q.push_back(cyc + LAT + 2);
        last_out_cyc = cyc + LAT + 2;
      end
      if (cfg_ack) begin
        model_opt = cfg_opt1_f;
        model_pv  = cfg_valid;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // Returns the cycle whose closing edge performs the handshake.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int acc_cyc);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_arg1  = a;
    in_arg2  = b;
    acc_cyc  = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) chk("send_timeout", 0, 1);
  endtask

  // Request an update and check ack latency, the clock-enable gap and the
  // parameter visibility. The ack is due the later of 2 cycles after the
  // request and 1 cycle after the last outstanding result.
  task automatic do_cfg(input logic [W-1:0] opt, input logic pv, input logic drop_valid,
                        output int ack_cyc);
    int r;
    int exp_ack;
    @(posedge clk); #1;
    if (drop_valid) in_valid = 1'b0;
    cfg_req    = 1'b1;
    cfg_opt1_f = opt;
    cfg_valid  = pv;
    r          = cyc;
    exp_ack    = (last_out_cyc + 1 > r + 2) ? last_out_cyc + 1 : r + 2;
    ack_cyc    = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cfg_ack) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (ack_cyc < 0) begin
      chk("cfg_ack_timeout", 0, 1);
      cfg_req = 1'b0;
    end else begin
      chk("cfg_ack_latency", ack_cyc - r, exp_ack - r);
      chk("param_load_with_ack", dut_param_load, 1);
      chk("clk_en_low_load", dut_clk_enable, 0);
      chk("drained_before_ack", exp_q.size(), 0);
      @(posedge clk); #1;
      cfg_req = 1'b0;
      for (int i = 1; i <= SET; i++) begin
        @(negedge clk);
        chk("clk_en_low_settle", dut_clk_enable, 0);
        chk("in_ready_low_settle", in_ready, 0);
        chk("opt1_f_loaded", dut_opt1_f, opt);
        chk("param_valid_loaded", dut_param_valid, pv);
        chk("param_load_single", dut_param_load, 0);
      end
      @(negedge clk);
      chk("clk_en_resumed", dut_clk_enable, 1);
      chk("in_ready_resumed", in_ready, 1);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int acc0, acc, ack, base;
    logic [1:0] rst_state;

    vecs[0] = '{8'h08, 8'h01, 8'h09};
    vecs[1] = '{8'h10, 8'h02, 8'h12};
    vecs[2] = '{8'h30, 8'h03, 8'h33};
    vecs[3] = '{8'h70, 8'h05, 8'h75};

    // Reset values
    repeat (2) @(negedge clk);
    rst_state = dbg_state;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cfg_ack", cfg_ack, 0);
    chk("rst_clk_en", dut_clk_enable, 0);
    chk("rst_opt1_f", dut_opt1_f, 0);
    chk("rst_param_valid", dut_param_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rel_outputs_zero", {out_valid, out_data, cfg_ack, dut_param_load, busy,
                             dut_inputArg1, dut_inputArg2, dut_opt1_f, dut_param_valid}, 0);
    chk("rel_in_ready", in_ready, 1);
    @(negedge clk);
    chk("run_clk_en", dut_clk_enable, 1);

    // Streaming, table driven
    base = obs_q.size();
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].a, vecs[i].b, acc);
      if (i == 0) acc0 = acc;
    end
    idle(LAT + 4);
    chk("stream_count", obs_q.size() - base, 4);
    for (int i = 0; i < 4 && base + i < obs_q.size(); i++) begin
      chk("stream_data", obs_q[base+i], vecs[i].exp);
      chk("stream_cycle", obs_t_q[base+i], acc0 + LAT + 2 + i);
    end

    // Config during streaming
    fork
      begin
        for (int i = 0; i < 6; i++) send(8'(8'h20 + i), 8'(i), acc);
        idle(1);
      end
      begin
        repeat (3) @(posedge clk);
        do_cfg(8'h02, 1'b1, 1'b0, ack);
      end
    join
    idle(LAT + 4);
    chk("stream_cfg_opt1_f", dut_opt1_f, 8'h02);

    // Collision of in_valid and cfg_req
    fork
      begin
        send(8'h08, 8'h07, acc);
        idle(1);
      end
      do_cfg(8'h11, 1'b0, 1'b0, ack);
    join
    chk("collision_accept_cycle", acc - ack, SET + 1);
    idle(LAT + 4);

    // Reset during DRAIN with one sample in flight
    do_cfg(8'h02, 1'b1, 1'b1, ack);
    @(posedge clk); #1;
    in_valid = 1'b1; in_arg1 = 8'h3c; in_arg2 = 8'h01;
    @(negedge clk);
    chk("drain_pre_handshake", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_req = 1'b1; cfg_opt1_f = 8'h44; cfg_valid = 1'b1;
    @(posedge clk); #1;
    chk("drain_busy", busy, 1);
    chk("drain_in_ready", in_ready, 0);
    chk("dbg_state_left_run", dbg_state != rst_state, 1);
    reset = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_opt1_f", dut_opt1_f, 0);
    chk("async_rst_clk_en", dut_clk_enable, 0);
    chk("async_rst_busy", busy, 0);
    cfg_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_out_valid", out_valid, 0);
      chk("rst_no_cfg_ack", cfg_ack, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_cfg_ack", cfg_ack, 0);
      chk("post_rst_opt1_f", dut_opt1_f, 0);
    end

    // Randomized traffic with interleaved updates
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0: do_cfg(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, ack);
        1: begin
          fork
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), acc);
            do_cfg(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, ack);
          join
          chk("rand_collision_accept", acc - ack, SET + 1);
        end
        default: begin
          idle($urandom_range(0, 2));
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), acc);
        end
      endcase
    end
    idle(LAT + 6);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("idle_not_busy", busy, 0);

`ifdef SIMPLE_SEQ_STATS_EN
    // Statistics counters
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) send(8'(i), 8'h01, acc);
    do_cfg(8'h05, 1'b1, 1'b1, ack);
    for (int i = 0; i < 3; i++) send(8'(i + 3), 8'h02, acc);
    do_cfg(8'h06, 1'b0, 1'b1, ack);
    idle(LAT + 4);
    chk("stats_sample_count", sample_count, 6);
    chk("stats_cfg_count", cfg_count, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
